// File: rtl/wam_pkg.sv
// Shared constants and helpers for the whack-a-mole key matrix.
// Key numbering matches LEDR[8:0]: key = col*NUM_COLS + row.
package wam_pkg;

  localparam int NUM_ROWS = 3;
  localparam int NUM_COLS = 3;
  localparam int NUM_KEYS = 9;

  localparam logic [3:0] KEY_NONE = 4'hF;

  typedef logic [1:0] col_idx_t;

  function automatic logic [3:0] key_index(input logic [1:0] col, input logic [1:0] row);
    return 4'(col) * 4'(NUM_COLS) + 4'(row);
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Whole-frame debouncer and press-event generator for the 3x3 key matrix.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   frame_valid       one-cycle strobe, frame holds a complete snapshot
//   frame[8:0]        raw key snapshot, bit i = key i seen pressed
//   keys_down[8:0]    debounced key state
//   key_event         one-cycle pulse on a newly debounced press
//   key_code[3:0]     lowest newly pressed key, held between events
//   key_multi         with key_event: more than one key newly pressed
module keypad_debounce
  import wam_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_valid,
  input  logic [NUM_KEYS-1:0] frame,
  output logic [NUM_KEYS-1:0] keys_down,
  output logic                key_event,
  output logic [3:0]          key_code,
  output logic                key_multi
);

  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CW-1:0] STABLE_MAX = CW'(DEBOUNCE_FRAMES);

  logic [NUM_KEYS-1:0] cand_q, cand_d;
  logic [CW-1:0]       stable_q, stable_d;
  logic [NUM_KEYS-1:0] down_q, down_d;
  logic                event_q, event_d;
  logic [3:0]          code_q, code_d;
  logic                multi_q, multi_d;

  logic [NUM_KEYS-1:0] new_keys;
  logic [3:0]          first_idx;

  always_comb begin
    cand_d    = cand_q;
    stable_d  = stable_q;
    down_d    = down_q;
    event_d   = 1'b0;
    code_d    = code_q;
    multi_d   = 1'b0;
    new_keys  = '0;
    first_idx = KEY_NONE;

    if (frame_valid) begin
      if (frame == cand_q) begin
        stable_d = (stable_q == STABLE_MAX) ? STABLE_MAX : stable_q + CW'(1);
      end else begin
        cand_d   = frame;
        stable_d = CW'(1);
      end
    end

    // Only rising bits count as presses; releases update keys_down silently.
    new_keys = cand_d & ~down_q;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (new_keys[i]) first_idx = 4'(i);
    end

    if (frame_valid && (stable_d == STABLE_MAX) && (cand_d != down_q)) begin
      down_d = cand_d;
      if (new_keys != '0) begin
        event_d = 1'b1;
        code_d  = first_idx;
        // x & (x-1) is nonzero exactly when more than one bit is set
        multi_d = |(new_keys & (new_keys - NUM_KEYS'(1)));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cand_q   <= '0;
      stable_q <= '0;
      down_q   <= '0;
      event_q  <= 1'b0;
      code_q   <= KEY_NONE;
      multi_q  <= 1'b0;
    end else begin
      cand_q   <= cand_d;
      stable_q <= stable_d;
      down_q   <= down_d;
      event_q  <= event_d;
      code_q   <= code_d;
      multi_q  <= multi_d;
    end
  end

  assign keys_down = down_q;
  assign key_event = event_q;
  assign key_code  = code_q;
  assign key_multi = multi_q;

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning front end of the 3x3 key matrix.
// Drives one column low at a time, samples the rows at the end of each
// column dwell, assembles a 9-bit frame and hands it to the debouncer.
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   key_matrix_row[2:0]  row lines, active-low
//   key_matrix_col[2:0]  column drive, active-low one-cold
//   keys_down[8:0]       debounced key state
//   key_event            one-cycle pulse on a newly debounced press
//   key_code[3:0]        index of the reported key
//   key_multi            more than one key newly pressed
module keypad_scanner
  import wam_pkg::*;
#(
  parameter int SCAN_TICKS      = 50_000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] key_matrix_row,
  output logic [NUM_COLS-1:0] key_matrix_col,
  output logic [NUM_KEYS-1:0] keys_down,
  output logic                key_event,
  output logic [3:0]          key_code,
  output logic                key_multi
);

  localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
  localparam col_idx_t      COL_LAST  = col_idx_t'(NUM_COLS - 1);

  logic [TW-1:0]       tick_q, tick_d;
  col_idx_t            col_q, col_d;
  logic [NUM_KEYS-1:0] snap_q, snap_d;
  logic                frame_valid_q, frame_valid_d;
  logic                wrap;

  assign wrap = (tick_q == TICK_LAST);

  always_comb begin
    tick_d        = wrap ? '0 : tick_q + TW'(1);
    col_d         = col_q;
    snap_d        = snap_q;
    frame_valid_d = 1'b0;

    if (wrap) begin
      // Sampling at the very end of the dwell gives the rows time to settle.
      for (int r = 0; r < NUM_ROWS; r++) begin
        snap_d[key_index(col_q, 2'(r))] = ~key_matrix_row[r];
      end
      col_d         = (col_q == COL_LAST) ? '0 : col_q + 2'd1;
      frame_valid_d = (col_q == COL_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q        <= '0;
      col_q         <= '0;
      snap_q        <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      tick_q        <= tick_d;
      col_q         <= col_d;
      snap_q        <= snap_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  assign key_matrix_col = ~(3'b001 << col_q);

  keypad_debounce #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_debounce (
    .clk        (clk),
    .reset      (reset),
    .frame_valid(frame_valid_q),
    .frame      (snap_q),
    .keys_down  (keys_down),
    .key_event  (key_event),
    .key_code   (key_code),
    .key_multi  (key_multi)
  );

endmodule
